// File: rtl/register_file_sb.sv
// General-purpose register file with a per-register pending-write scoreboard.
// Two combinational read ports, one synchronous write port, optional write-to-read bypass.
module register_file_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int BYPASS = 1,
  localparam int AW    = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            RegWrite,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] WriteData,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] ReadData1,
  output logic [XLEN-1:0] ReadData2,
  input  logic            Reserve,
  input  logic [AW-1:0]   ReserveRd,
  output logic            Busy1,
  output logic            Busy2,
  output logic            BusyRd
);

  // Register 0 is never stored: it reads as zero and is never pending.
  logic [XLEN-1:0] regs_q [1:NREGS-1];
  logic [XLEN-1:0] regs_d [1:NREGS-1];
  logic [NREGS-1:1] pend_q;
  logic [NREGS-1:1] pend_d;

  // Next-state: writes clear the pending bit, then a same-edge reservation
  // re-sets it, so the newer producer wins.
  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    for (int i = 1; i < NREGS; i++) begin
      if (RegWrite && (rd == AW'(i))) begin
        regs_d[i] = WriteData;
        pend_d[i] = 1'b0;
      end
      if (Reserve && (ReserveRd == AW'(i))) begin
        pend_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 1; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

  // Address decode loops only match 1..NREGS-1, so zero and out-of-range
  // addresses naturally fall through to the zero defaults.
  always_comb begin
    ReadData1 = '0;
    ReadData2 = '0;
    Busy1     = 1'b0;
    Busy2     = 1'b0;
    BusyRd    = 1'b0;
    if (rst_n) begin
      for (int i = 1; i < NREGS; i++) begin
        if (rs1 == AW'(i)) begin
          if ((BYPASS != 0) && RegWrite && (rd == rs1)) begin
            ReadData1 = WriteData;
            Busy1     = 1'b0;
          end else begin
            ReadData1 = regs_q[i];
            Busy1     = pend_q[i];
          end
        end
        if (rs2 == AW'(i)) begin
          if ((BYPASS != 0) && RegWrite && (rd == rs2)) begin
            ReadData2 = WriteData;
            Busy2     = 1'b0;
          end else begin
            ReadData2 = regs_q[i];
            Busy2     = pend_q[i];
          end
        end
        if (ReserveRd == AW'(i)) begin
          BusyRd = pend_q[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_register_file_sb.sv
// Bench for register_file_sb: three configurations (bypass/32, no-bypass/32, bypass/20)
// share one stimulus stream and are checked against an array-based reference model.
module tb_register_file_sb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        reg_write = 1'b0;
  logic [4:0]  rd = '0;
  logic [31:0] write_data = '0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic        reserve = 1'b0;
  logic [4:0]  reserve_rd = '0;

  logic [31:0] rdata1 [3];
  logic [31:0] rdata2 [3];
  logic        busy1  [3];
  logic        busy2  [3];
  logic        busy_rd[3];

  int errors = 0;
  int checks = 0;

  int nregs  [3] = '{32, 32, 20};
  bit bypass [3] = '{1'b1, 1'b0, 1'b1};

  logic [31:0] m_regs [3][64];
  bit          m_pend [3][64];

  always #5 clk = ~clk;

  register_file_sb #(.XLEN(32), .NREGS(32), .BYPASS(1)) dut_byp (
    .clk(clk), .rst_n(rst_n), .RegWrite(reg_write), .rd(rd), .WriteData(write_data),
    .rs1(rs1), .rs2(rs2), .ReadData1(rdata1[0]), .ReadData2(rdata2[0]),
    .Reserve(reserve), .ReserveRd(reserve_rd),
    .Busy1(busy1[0]), .Busy2(busy2[0]), .BusyRd(busy_rd[0])
  );

  register_file_sb #(.XLEN(32), .NREGS(32), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .RegWrite(reg_write), .rd(rd), .WriteData(write_data),
    .rs1(rs1), .rs2(rs2), .ReadData1(rdata1[1]), .ReadData2(rdata2[1]),
    .Reserve(reserve), .ReserveRd(reserve_rd),
    .Busy1(busy1[1]), .Busy2(busy2[1]), .BusyRd(busy_rd[1])
  );

  register_file_sb #(.XLEN(32), .NREGS(20), .BYPASS(1)) dut_n20 (
    .clk(clk), .rst_n(rst_n), .RegWrite(reg_write), .rd(rd), .WriteData(write_data),
    .rs1(rs1), .rs2(rs2), .ReadData1(rdata1[2]), .ReadData2(rdata2[2]),
    .Reserve(reserve), .ReserveRd(reserve_rd),
    .Busy1(busy1[2]), .Busy2(busy2[2]), .BusyRd(busy_rd[2])
  );

  // Reference model: architectural state updated once per rising edge.
  always @(posedge clk) begin
    for (int c = 0; c < 3; c++) begin
      if (!rst_n) begin
        for (int r = 0; r < 64; r++) begin
          m_regs[c][r] = '0;
          m_pend[c][r] = 1'b0;
        end
      end else begin
        if (reg_write && rd != 0 && int'(rd) < nregs[c]) begin
          m_regs[c][rd] = write_data;
          m_pend[c][rd] = 1'b0;
        end
        if (reserve && reserve_rd != 0 && int'(reserve_rd) < nregs[c]) begin
          m_pend[c][reserve_rd] = 1'b1;
        end
      end
    end
  end

  function automatic logic [31:0] exp_data(int c, logic [4:0] rs);
    if (!rst_n || rs == 0 || int'(rs) >= nregs[c]) return '0;
    if (bypass[c] && reg_write && rd == rs) return write_data;
    return m_regs[c][rs];
  endfunction

  function automatic logic exp_busy(int c, logic [4:0] rs);
    if (!rst_n || rs == 0 || int'(rs) >= nregs[c]) return 1'b0;
    if (bypass[c] && reg_write && rd == rs) return 1'b0;
    return m_pend[c][rs];
  endfunction

  function automatic logic exp_busy_rd(int c);
    if (!rst_n || reserve_rd == 0 || int'(reserve_rd) >= nregs[c]) return 1'b0;
    return m_pend[c][reserve_rd];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("%s cfg%0d rdata1", tag, c), rdata1[c], exp_data(c, rs1));
      check($sformatf("%s cfg%0d rdata2", tag, c), rdata2[c], exp_data(c, rs2));
      check($sformatf("%s cfg%0d busy1", tag, c), {31'b0, busy1[c]}, {31'b0, exp_busy(c, rs1)});
      check($sformatf("%s cfg%0d busy2", tag, c), {31'b0, busy2[c]}, {31'b0, exp_busy(c, rs2)});
      check($sformatf("%s cfg%0d busy_rd", tag, c), {31'b0, busy_rd[c]}, {31'b0, exp_busy_rd(c)});
    end
  endtask

  task automatic drive(input bit rn, input bit we, input logic [4:0] a_rd, input logic [31:0] wd,
                       input logic [4:0] a1, input logic [4:0] a2, input bit res,
                       input logic [4:0] a_rr);
    @(negedge clk);
    rst_n      = rn;
    reg_write  = we;
    rd         = a_rd;
    write_data = wd;
    rs1        = a1;
    rs2        = a2;
    reserve    = res;
    reserve_rd = a_rr;
    #1;
  endtask

  typedef struct {
    bit          rn;
    bit          we;
    logic [4:0]  a_rd;
    logic [31:0] wd;
    logic [4:0]  a1;
    logic [4:0]  a2;
    bit          res;
    logic [4:0]  a_rr;
    logic [31:0] e_d1;
    logic [31:0] e_d2;
    bit          e_b1;
    bit          e_b2;
    bit          e_brd;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit rn, bit we, logic [4:0] a_rd, logic [31:0] wd,
                              logic [4:0] a1, logic [4:0] a2, bit res, logic [4:0] a_rr,
                              logic [31:0] e_d1, logic [31:0] e_d2, bit e_b1, bit e_b2, bit e_brd);
    vec_t v;
    v = '{rn, we, a_rd, wd, a1, a2, res, a_rr, e_d1, e_d2, e_b1, e_b2, e_brd};
    vecs.push_back(v);
  endfunction

  initial begin
    // Expectations are for the bypass / 32-register instance; rows are consecutive cycles.
    //  rn we rd  wd            rs1 rs2 res rrd   d1            d2            b1 b2 brd
    add(0, 1,  5, 32'h1111,     5,  5,  1,  5,   32'h0,        32'h0,        0, 0, 0);
    add(1, 1,  5, 32'h12345678, 0,  0,  0,  0,   32'h0,        32'h0,        0, 0, 0);
    add(1, 0,  0, 32'h0,        5,  0,  0,  0,   32'h12345678, 32'h0,        0, 0, 0);
    add(1, 1,  0, 32'hFFFFFFFF, 0,  0,  1,  0,   32'h0,        32'h0,        0, 0, 0);
    add(1, 0,  0, 32'h0,        0,  5,  0,  0,   32'h0,        32'h12345678, 0, 0, 0);
    add(1, 1,  7, 32'hA5A5A5A5, 5,  7,  0,  0,   32'h12345678, 32'hA5A5A5A5, 0, 0, 0);
    add(1, 0,  0, 32'h0,        3,  7,  1,  3,   32'h0,        32'hA5A5A5A5, 0, 0, 0);
    add(1, 0,  0, 32'h0,        3,  3,  0,  3,   32'h0,        32'h0,        1, 1, 1);
    add(1, 1,  3, 32'h55,       3,  0,  0,  3,   32'h55,       32'h0,        0, 0, 1);
    add(1, 0,  0, 32'h0,        3,  0,  0,  3,   32'h55,       32'h0,        0, 0, 0);
    add(1, 0,  0, 32'h0,        4,  0,  1,  4,   32'h0,        32'h0,        0, 0, 0);
    add(1, 1,  4, 32'h11,       4,  4,  1,  4,   32'h11,       32'h11,       0, 0, 1);
    add(1, 0,  0, 32'h0,        4,  0,  0,  4,   32'h11,       32'h0,        1, 0, 1);
    add(1, 1,  4, 32'h22,       4,  6,  1,  6,   32'h22,       32'h0,        0, 0, 0);
    add(1, 0,  0, 32'h0,        4,  6,  0,  6,   32'h22,       32'h0,        0, 1, 1);
    add(1, 1,  9, 32'hDEADBEEF, 0,  0,  1,  9,   32'h0,        32'h0,        0, 0, 0);
    add(1, 0,  0, 32'h0,        9,  9,  0,  9,   32'hDEADBEEF, 32'hDEADBEEF, 1, 1, 1);
    add(0, 1,  9, 32'h1234,     9,  9,  1, 10,   32'h0,        32'h0,        0, 0, 0);
    add(1, 0,  0, 32'h0,        9,  6,  0,  9,   32'h0,        32'h0,        0, 0, 0);
    add(1, 1, 25, 32'hCAFEF00D, 25, 5,  0,  0,   32'hCAFEF00D, 32'h0,        0, 0, 0);
    add(1, 0,  0, 32'h0,        25, 5,  1, 25,   32'hCAFEF00D, 32'h0,        0, 0, 0);
    add(1, 0,  0, 32'h0,        25, 5,  0, 25,   32'hCAFEF00D, 32'h0,        1, 0, 1);

    foreach (vecs[i]) begin
      drive(vecs[i].rn, vecs[i].we, vecs[i].a_rd, vecs[i].wd, vecs[i].a1, vecs[i].a2,
            vecs[i].res, vecs[i].a_rr);
      check($sformatf("vec%0d rdata1", i), rdata1[0], vecs[i].e_d1);
      check($sformatf("vec%0d rdata2", i), rdata2[0], vecs[i].e_d2);
      check($sformatf("vec%0d busy1", i), {31'b0, busy1[0]}, {31'b0, vecs[i].e_b1});
      check($sformatf("vec%0d busy2", i), {31'b0, busy2[0]}, {31'b0, vecs[i].e_b2});
      check($sformatf("vec%0d busy_rd", i), {31'b0, busy_rd[0]}, {31'b0, vecs[i].e_brd});
      check_model($sformatf("vec%0d", i));
    end

    // Without bypass the old value is seen until the write edge has passed.
    drive(1, 1, 12, 32'h77, 0, 12, 0, 0);
    check("nb same-cycle old value", rdata2[1], 32'h0);
    check("byp same-cycle new value", rdata2[0], 32'h77);
    drive(1, 0, 0, 32'h0, 0, 12, 0, 0);
    check("nb value after edge", rdata2[1], 32'h77);

    // Twenty-register instance: address 25 is out of range for read, write and reserve.
    drive(1, 1, 25, 32'h5A, 25, 19, 1, 25);
    check("n20 oob read same cycle", rdata1[2], 32'h0);
    check("n20 oob busy_rd", {31'b0, busy_rd[2]}, 32'h0);
    drive(1, 0, 0, 32'h0, 25, 19, 0, 25);
    check("n20 oob read after write", rdata1[2], 32'h0);
    check("n20 oob busy1", {31'b0, busy1[2]}, 32'h0);
    check("n20 oob busy_rd after reserve", {31'b0, busy_rd[2]}, 32'h0);
    check_model("n20 seq");

    // Randomized traffic, biased towards address collisions between ports.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] r_rd;
      logic [4:0] r_a1;
      logic [4:0] r_a2;
      logic [4:0] r_rr;
      r_rd = 5'($urandom_range(0, 31));
      r_a1 = ($urandom_range(0, 3) == 0) ? r_rd : 5'($urandom_range(0, 31));
      r_a2 = ($urandom_range(0, 3) == 0) ? r_rd : 5'($urandom_range(0, 31));
      r_rr = ($urandom_range(0, 3) == 0) ? r_rd : 5'($urandom_range(0, 31));
      drive(($urandom_range(0, 39) != 0), 1'($urandom_range(0, 1)), r_rd, $urandom,
            r_a1, r_a2, 1'($urandom_range(0, 1)), r_rr);
      check_model($sformatf("rand%0d", n));
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
